// File: rtl/maindec_mc_if.sv
// Control bundle between the multicycle main decoder and the shared datapath.
// The decoder side uses the master modport; the datapath/IR side uses slave.
interface maindec_mc_if #(
    parameter int unsigned OP_W = 11
);
    logic [OP_W-1:0] Op;
    logic            mem_ready;
    logic            Reg2Loc;
    logic            ALUSrc;
    logic            MemtoReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Branch;
    logic            UncondBranch;
    logic            IRWrite;
    logic            PCWrite;
    logic [1:0]      ALUOp;
    logic            instr_done;
    logic            illegal;

    modport master (
        input  Op, mem_ready,
        output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, IRWrite, PCWrite, ALUOp, instr_done, illegal
    );

    modport slave (
        output Op, mem_ready,
        input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, IRWrite, PCWrite, ALUOp, instr_done, illegal
    );
endinterface

// File: rtl/maindec_mc.sv
// Multicycle LEGv8 main decoder: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, stalling memory states on the mem_ready handshake.
module maindec_mc #(
    parameter int unsigned OP_W        = 11,
    parameter bit          EN_IMM      = 1'b1,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    maindec_mc_if.master  bus
);
    localparam int unsigned DEC_W = 11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DEC_W-1:0] op;
    logic             rdy;
    logic             is_ldur;
    logic             is_stur;
    logic             is_rtype;
    logic             is_itype;
    logic             is_cbz;
    logic             is_b;

    // Only the top 11 opcode bits carry the instruction class.
    assign op  = bus.Op[OP_W-1 -: DEC_W];
    assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    assign is_ldur  = (op == 11'b11111000010);
    assign is_stur  = (op == 11'b11111000000);
    assign is_rtype = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                      (op == 11'b10001010000) || (op == 11'b10101010000);
    assign is_itype = EN_IMM && ((op[10:1] == 10'b1001000100) ||
                                 (op[10:1] == 10'b1101000100));
    assign is_cbz   = (op[10:3] == 8'b10110100);
    assign is_b     = (op[10:5] == 6'b000101);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; stray encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_ldur || is_stur)        state_d = S_MEMADR;
                else if (is_rtype || is_itype) state_d = S_EXEC;
                else if (is_cbz)               state_d = S_BRANCH;
                else if (is_b)                 state_d = S_JUMP;
                else                           state_d = S_TRAP;
            end
            S_MEMADR: state_d = is_stur ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode, held at zero for as long as reset is asserted.
    always_comb begin
        bus.Reg2Loc      = 1'b0;
        bus.ALUSrc       = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.Branch       = 1'b0;
        bus.UncondBranch = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.ALUOp        = 2'b00;
        bus.instr_done   = 1'b0;
        bus.illegal      = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.IRWrite = rdy;
                    bus.PCWrite = rdy;
                end
                S_DECODE: bus.Reg2Loc = is_stur || is_cbz;
                S_MEMADR: bus.ALUSrc = 1'b1;
                S_MEMRD: begin
                    bus.ALUSrc  = 1'b1;
                    bus.MemRead = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.Reg2Loc    = 1'b1;
                    bus.ALUSrc     = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = rdy;
                end
                S_EXEC: begin
                    bus.ALUSrc = is_itype;
                    bus.ALUOp  = is_itype ? 2'b11 : 2'b10;
                end
                S_ALUWB: begin
                    bus.ALUSrc     = is_itype;
                    bus.ALUOp      = is_itype ? 2'b11 : 2'b10;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.Reg2Loc    = 1'b1;
                    bus.ALUOp      = 2'b01;
                    bus.Branch     = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.UncondBranch = 1'b1;
                    bus.instr_done   = 1'b1;
                end
                S_TRAP: begin
                    bus.illegal    = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maindec_mc.sv
// Scoreboard bench for maindec_mc: three parameter variants share stimulus,
// only one is out of reset at a time; per-instruction signatures are checked.
module tb_maindec_mc;
    localparam int S_R2L = 0, S_SRC = 1, S_M2R = 2, S_RW = 3, S_MR = 4, S_MW = 5, S_BR = 6;
    localparam int S_UB = 7, S_IRW = 8, S_PCW = 9, S_OP0 = 10, S_OP1 = 11, S_DONE = 12, S_ILL = 13;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    typedef enum int {C_LD, C_ST, C_R, C_I, C_CBZ, C_B, C_ILL} cls_t;

    typedef struct packed {
        logic [7:0]        lat;
        logic [13:0][7:0]  cnt;
        logic [13:0]       last;
    } exp_t;

    logic        clk;
    logic [2:0]  rst_n_v;
    logic [10:0] op_drv;
    logic        mem_rdy;
    logic [13:0] ov [3];
    int          cur;
    exp_t        sbq [$];
    int          n_tests;
    int          n_fail;
    int          acc [14];
    int          lat_acc;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g
        maindec_mc_if #(.OP_W(11)) bus ();
        assign bus.Op        = op_drv;
        assign bus.mem_ready = mem_rdy;
        maindec_mc #(.OP_W(11), .EN_IMM(gi != 1), .MEM_WAIT_EN(gi != 2)) dut (
            .clk   (clk),
            .reset (rst_n_v[gi]),
            .bus   (bus)
        );
        assign ov[gi] = {bus.illegal, bus.instr_done, bus.ALUOp, bus.PCWrite, bus.IRWrite,
                         bus.UncondBranch, bus.Branch, bus.MemWrite, bus.MemRead,
                         bus.RegWrite, bus.MemtoReg, bus.ALUSrc, bus.Reg2Loc};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h want %0h", name, cur, $time, got, want);
        end
    endtask

    function automatic cls_t classify(input logic [10:0] op, input bit en_imm);
        if (op == OP_LDUR) return C_LD;
        if (op == OP_STUR) return C_ST;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (en_imm && (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100)) return C_I;
        if (op[10:3] == 8'b10110100) return C_CBZ;
        if (op[10:5] == 6'b000101) return C_B;
        return C_ILL;
    endfunction

    // Expected latency, per-signal high-cycle counts and final-cycle outputs.
    function automatic exp_t model(input logic [10:0] op, input int wf_in, input int wm_in,
                                   input bit en_imm, input bit wait_en);
        exp_t        e;
        int          c [14];
        int          wf, wm, lat;
        logic [13:0] last;
        wf = wait_en ? wf_in : 0;
        wm = wait_en ? wm_in : 0;
        foreach (c[i]) c[i] = 0;
        last = '0;
        c[S_MR] = 1 + wf; c[S_IRW] = 1; c[S_PCW] = 1; c[S_DONE] = 1;
        last[S_DONE] = 1'b1;
        case (classify(op, en_imm))
            C_LD: begin
                lat = 5 + wf + wm; c[S_SRC] = 2 + wm; c[S_MR] += 1 + wm;
                c[S_RW] = 1; c[S_M2R] = 1; last[S_RW] = 1'b1; last[S_M2R] = 1'b1;
            end
            C_ST: begin
                lat = 4 + wf + wm; c[S_R2L] = 2 + wm; c[S_SRC] = 2 + wm; c[S_MW] = 1 + wm;
                last[S_R2L] = 1'b1; last[S_SRC] = 1'b1; last[S_MW] = 1'b1;
            end
            C_R: begin
                lat = 4 + wf; c[S_OP1] = 2; c[S_RW] = 1;
                last[S_OP1] = 1'b1; last[S_RW] = 1'b1;
            end
            C_I: begin
                lat = 4 + wf; c[S_SRC] = 2; c[S_OP1] = 2; c[S_OP0] = 2; c[S_RW] = 1;
                last[S_SRC] = 1'b1; last[S_OP1] = 1'b1; last[S_OP0] = 1'b1; last[S_RW] = 1'b1;
            end
            C_CBZ: begin
                lat = 3 + wf; c[S_R2L] = 2; c[S_OP0] = 1; c[S_BR] = 1;
                last[S_R2L] = 1'b1; last[S_OP0] = 1'b1; last[S_BR] = 1'b1;
            end
            C_B: begin
                lat = 3 + wf; c[S_UB] = 1; last[S_UB] = 1'b1;
            end
            default: begin
                lat = 3 + wf; c[S_ILL] = 1; last[S_ILL] = 1'b1;
            end
        endcase
        e.lat = 8'(lat);
        for (int i = 0; i < 14; i++) e.cnt[i] = 8'(c[i]);
        e.last = last;
        return e;
    endfunction

    // Monitor: reset-zero checks, strobe exclusivity, scoreboard pop on instr_done.
    always @(negedge clk) begin
        logic [13:0]      v;
        logic [13:0][7:0] got_cnt;
        exp_t             e;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n_v[d]) begin
                n_tests++;
                if (ov[d] !== 14'd0) begin
                    n_fail++;
                    $display("FAIL reset_zero dut%0d @%0t: got %0h want 0", d, $time, ov[d]);
                end
            end
        end
        if (!rst_n_v[cur]) begin
            foreach (acc[i]) acc[i] = 0;
            lat_acc = 0;
        end else begin
            v = ov[cur];
            lat_acc++;
            for (int i = 0; i < 14; i++) if (v[i]) acc[i]++;
            chk("strobe_excl", 128'(($countones({v[S_RW], v[S_MW], v[S_BR], v[S_UB]}) > 1)), 128'd0);
            if (v[S_DONE]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 128'd1, 128'd0);
                end else begin
                    e = sbq.pop_front();
                    for (int i = 0; i < 14; i++) got_cnt[i] = 8'(acc[i]);
                    chk("latency", 128'(lat_acc), 128'(e.lat));
                    chk("signal_counts", 128'(got_cnt), 128'(e.cnt));
                    chk("final_outputs", 128'(v), 128'(e.last));
                end
                foreach (acc[i]) acc[i] = 0;
                lat_acc = 0;
            end
        end
    end

    // Drives one instruction starting in FETCH; returns just after its last edge.
    task automatic run_instr(input logic [10:0] op, input int wf, input int wm, input bit rdy_lo);
        bit   en_imm, we, mem;
        exp_t e;
        en_imm = (cur != 1);
        we     = (cur != 2);
        mem    = (classify(op, en_imm) == C_LD) || (classify(op, en_imm) == C_ST);
        e      = model(op, wf, wm, en_imm, we);
        sbq.push_back(e);
        op_drv = op;
        for (int k = 0; k < int'(e.lat); k++) begin
            if (!we)                                          mem_rdy = rdy_lo ? 1'b0 : 1'($urandom_range(0, 1));
            else if (k < wf)                                  mem_rdy = 1'b0;
            else if (k == wf)                                 mem_rdy = 1'b1;
            else if (mem && k >= wf + 3 && k < wf + 3 + wm)   mem_rdy = 1'b0;
            else if (mem && k == wf + 3 + wm)                 mem_rdy = 1'b1;
            else                                              mem_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] rand_op();
        logic [10:0] r;
        r = 11'($urandom);
        case ($urandom_range(0, 9))
            0: return OP_LDUR;
            1: return OP_STUR;
            2: return 11'b10001011000;
            3: return 11'b11001011000;
            4: return 11'b10001010000;
            5: return 11'b10101010000;
            6: return {($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100, r[0]};
            7: return {8'b10110100, r[2:0]};
            8: return {6'b000101, r[4:0]};
            default: return r;
        endcase
    endfunction

    task automatic rand_instrs(input int n);
        for (int i = 0; i < n; i++)
            run_instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        logic [10:0] dir_ops [7];
        dir_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                    11'b10010001000, 11'b10110100000, 11'b00010100000};
        n_tests = 0; n_fail = 0; lat_acc = 0;
        foreach (acc[i]) acc[i] = 0;
        cur = 0; rst_n_v = 3'b000; op_drv = OP_LDUR; mem_rdy = 1'b1;

        #27 rst_n_v[0] = 1'b1;
        run_instr(OP_LDUR, 0, 0, 1'b0);
        run_instr(OP_STUR, 0, 3, 1'b0);
        foreach (dir_ops[i]) run_instr(dir_ops[i], 0, 0, 1'b0);
        run_instr(11'b11111111111, 0, 0, 1'b0);
        rand_instrs(40);

        // Abort an LDUR while it is stalled in MEMRD.
        op_drv = OP_LDUR; mem_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n_v[0] = 1'b0;
        #1 chk("abort_outputs", 128'(ov[0]), 128'd0);
        @(posedge clk); #1;

        cur = 2; rst_n_v[2] = 1'b1;
        run_instr(OP_LDUR, 0, 0, 1'b1);
        run_instr(OP_STUR, 2, 2, 1'b1);
        rand_instrs(20);

        rst_n_v[2] = 1'b0; cur = 1; rst_n_v[1] = 1'b1;
        run_instr(11'b10010001000, 0, 0, 1'b0);
        run_instr(11'b11010001001, 1, 0, 1'b0);
        rand_instrs(20);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        chk("sb_drain", 128'(sbq.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
Multicycle successor to the single-cycle LEGv8 main decoder. It is a Moore FSM that sequences each instruction over several clock cycles: fetch, decode, execute, memory and writeback. Memory states stall on a ready handshake. It sits between the instruction register and the shared ALU/memory datapath of the multicycle processor. It supports LDUR, STUR, CBZ, B, R-type ADD/SUB/AND/ORR, and optionally ADDI/SUBI, and it flags illegal opcodes.

Parameters:
OP_W, 11, opcode width presented on Op; must be >= 11, and only Op[OP_W-1 -: 11] is decoded.
EN_IMM, 1, 1 = decode ADDI/SUBI; 0 = treat them as illegal.
MEM_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
Op  input  OP_W  opcode field from the instruction register; stable from DECODE until FETCH
mem_ready  input  1  memory completes the current access this cycle
Reg2Loc  output  1  read-register-2 select (Rt)
ALUSrc  output  1  ALU B operand = sign-extended immediate
MemtoReg  output  1  writeback source = memory data
RegWrite  output  1  register file write enable
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
Branch  output  1  conditional PC write if zero (CBZ)
UncondBranch  output  1  unconditional PC write (B)
IRWrite  output  1  instruction register load
PCWrite  output  1  PC <- PC+4
ALUOp  output  2  00 add, 01 pass B, 10 R-type funct, 11 I-type (ALU decoder uses Op[9])
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal  output  1  one-cycle pulse: unrecognised opcode

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP.
- Reset asserted (low):
  - state goes to FETCH asynchronously;
  - all outputs are forced to 0 while reset is low;
  - after release, the first rising edge is spent in FETCH.
- Reset mid-instruction aborts the instruction with no further write strobes.
- Outputs are Moore, decoded from state (plus opcode where noted). Any output not listed for a state is 0.
- FETCH: MemRead=1. IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready, otherwise holds.
- DECODE: Reg2Loc=1 if the opcode is STUR or CBZ. Next state:
  - LDUR 11111000010 or STUR 11111000000 -> MEMADR
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC
  - with EN_IMM=1: ADDI Op[10:1]=1001000100 or SUBI 1101000100 -> EXEC
  - CBZ Op[10:3]=10110100 -> BRANCH
  - B Op[10:5]=000101 -> JUMP
  - anything else -> TRAP
- MEMADR: ALUSrc=1, ALUOp=00. Goes to MEMRD for LDUR, MEMWR for STUR.
- MEMRD: ALUSrc=1, MemRead=1. Goes to MEMWB when mem_ready, otherwise holds.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1. Goes to FETCH.
- MEMWR: Reg2Loc=1, ALUSrc=1, MemWrite=1. instr_done=mem_ready. Goes to FETCH when mem_ready, otherwise holds.
- EXEC: R-type gives ALUSrc=0, ALUOp=10; I-type gives ALUSrc=1, ALUOp=11. Goes to ALUWB.
- ALUWB: keeps the EXEC ALUSrc/ALUOp, plus RegWrite=1 and instr_done=1. Goes to FETCH.
- BRANCH: Reg2Loc=1, ALUOp=01, Branch=1, instr_done=1. Goes to FETCH.
- JUMP: UncondBranch=1, instr_done=1. Goes to FETCH.
- TRAP: illegal=1, instr_done=1, no write strobes. Goes to FETCH.
- Latency with mem_ready held at 1, FETCH to final state inclusive: LDUR 5, STUR 4, R/I 4, CBZ 3, B 3, illegal 3.
  - Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds 1 cycle (MEM_WAIT_EN=1).
- At most one of RegWrite, MemWrite, Branch, UncondBranch is high in any cycle.
- IRWrite/PCWrite are only high in FETCH.
- Unused encodings on the state register recover to FETCH.

Test Plan:
- Reset low for 27 ns, then high with mem_ready=1 and Op=11111000010 -> all outputs 0 during reset. Then states FETCH, DECODE, MEMADR, MEMRD, MEMWB; in MEMWB RegWrite=MemtoReg=1 and instr_done pulses once.
- STUR (11111000000) with mem_ready low for 3 cycles in MEMWR -> MemWrite=1, Reg2Loc=1 held 4 cycles; instr_done only in the final cycle; RegWrite stays 0.
- Each R-type (ADD, SUB, AND, ORR) and ADDI 10010001000 -> ALUWB shows {ALUSrc, ALUOp}=0_10 for R-type and 1_11 for ADDI, with RegWrite=1. Each instruction takes 4 cycles.
- CBZ 10110100000 then B 00010100000 -> BRANCH shows Reg2Loc=1, ALUOp=01, Branch=1; JUMP shows UncondBranch=1. Each takes 3 cycles.
- EN_IMM=0 with Op=10010001000, and EN_IMM=1 with Op=11111111111 -> TRAP, illegal pulses 1 cycle, no write strobes, returns to FETCH.
- Reset driven low during MEMRD, then MEM_WAIT_EN=0 with mem_ready=0 -> async return to FETCH with outputs 0. Afterwards LDUR completes in 5 cycles despite mem_ready=0.
